uart_rx_deser: RTL and testbench
================================

# uart_rx_deser

Serial-to-parallel UART receive engine for the UART subsystem. It recovers 8N1 frames (optionally 8E1) from the asynchronous serial line, validates start and stop bits, and presents each byte through a held-until-accepted handshake. It is the receiving end for the `UART` transmit path and drives the same `rx_*` status outputs used by the top level.

## Interface
- `DATA_BITS`, 8: payload bits per frame, LSB first.
- `OVERSAMPLE`, 16: oversample ticks per bit. Must be even and ≥4.
- `BAUD_DIV`, 1: `clka` cycles per oversample tick. Must be ≥1.
- `clka`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high.
- `rxd`  in  1  serial line; idle high; asynchronous to `clka`.
- `rx_rdy`  in  1  consumer accepts `rx_out` while `rx_done`=1.
- `rx_out`  out  DATA_BITS  received byte; valid while `rx_done`=1.
- `rx_done`  out  1  byte available; held until accepted.
- `rx_busy`  out  1  frame in progress (any state except IDLE).
- `rx_idle`  out  1  FSM in IDLE.
- `rx_error`  out  1  one-cycle pulse on a framing or parity error.
- `rx_overrun`  out  1  sticky; a frame completed while `rx_done`=1.
- `rstate`  out  4  FSM state code (debug).
- `rcount`  out  4  data bits captured in the current frame (debug).

## Operation
- `rxd` passes through a 2-flop synchronizer; both flops reset to 1. The falling-edge detector operates on the synchronized value.
- States and codes: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4, WAIT_HIGH=5.
- IDLE: on a synchronized falling edge, go to START, clear the tick and sample counters, and clear `rcount`.
- START: at sample count OVERSAMPLE/2−1 (the bit midpoint), sample the line.
  - Line=1: false start. Return to IDLE with no error.
  - Line=0: go to DATA with the sample counter cleared.
- DATA: sample every OVERSAMPLE ticks and shift right into the shift register (LSB first). `rcount` increments per bit.
  - After DATA_BITS samples, go to PARITY if it is enabled, otherwise go to STOP.
- PARITY: sample one bit. A mismatch sets an internal parity-error flag.
- STOP: sample the stop bit.
  - Stop=1 and no parity error: the byte is good; go to IDLE.
  - Stop=0: framing error. Pulse `rx_error`, discard the byte, and go to WAIT_HIGH.
  - Stop=1 with a parity error: pulse `rx_error`, discard the byte, and go to IDLE.
- WAIT_HIGH: stay until the synchronized line is 1, then go to IDLE. This handles break conditions.
- Good-byte delivery:
  - If `rx_done`=0: load `rx_out` and set `rx_done`.
  - If `rx_done`=1 (unaccepted): drop the new byte, set `rx_overrun`, and leave `rx_out` unchanged.
- Handshake: `rx_done`=1 and `rx_rdy`=1 on the same rising edge clears `rx_done` and `rx_overrun` on that edge.
- Delivery and acceptance on the same edge: the new byte loads, `rx_done` stays 1, and no overrun is flagged.
- Reset values: `rx_out`=0, `rx_done`=0, `rx_busy`=0, `rx_idle`=1, `rx_error`=0, `rx_overrun`=0, `rstate`=0, `rcount`=0.
- Mid-frame reset returns the block to IDLE immediately with no output pulse.

## Timing
- One bit time is OVERSAMPLE×BAUD_DIV `clka` cycles. The tick counter restarts on the start edge.
- Synchronizer plus edge detect adds 2 cycles from an `rxd` fall to START entry.
- `rx_done` and `rx_error` assert on the edge after the stop-bit midpoint sample.
- Example with BAUD_DIV=1, OVERSAMPLE=16, parity off: `rx_done` rises 2+7+9×16+1 = 154 cycles after the `rxd` falling edge.
- `rx_error` is exactly one cycle wide.
- `rx_busy` and `rx_idle` are registered from `rstate` in the same cycle.

## Configuration
- `UART_RX_PARITY_EN` defined: the PARITY state is present and one even-parity bit follows the data bits.
  - Parity mismatch pulses `rx_error` and discards the byte.
  - Frame length is 11 bits.
- Not defined: the PARITY state is unreachable and removed. State code 3 is never driven, and the frame is 10 bits.

## Structure
- `uart_pkg`: state enum with the codes above, plus default constants `UART_DATA_BITS`=8 and `UART_OVERSAMPLE`=16.
- Sub-module `uart_baud_tick`: BAUD_DIV divider with synchronous restart input; emits a one-cycle `tick`.
- Synchronizer, FSM, shift register and handshake live in `uart_rx_deser`.

## Test plan
- Clean byte: 0xE8 at BAUD_DIV=1, OVERSAMPLE=16, `rx_rdy` held 1 → `rx_out`=8'b11101000, `rx_done` high 1 cycle at cycle 154, `rx_error`=0, `rcount` reaches 8.
- Hold and overrun: 0x55 then 0xAA back-to-back with `rx_rdy`=0 → `rx_out` stays 0x55, `rx_overrun`=1. Then `rx_rdy` pulse → `rx_done`=0, `rx_overrun`=0.
- Glitch: `rxd` low for 4 cycles → START entered then IDLE, no `rx_done`, no `rx_error`.
- Framing and break: 0x3C with stop=0, line held low 100 cycles → one `rx_error` pulse, `rstate`=5 until the line rises, no `rx_done`.
- Reset mid-frame: `reset` asserted at cycle 60 of a frame → all outputs at reset values next cycle. A following 0x81 frame is received correctly.
- Parity (with `UART_RX_PARITY_EN`): 0x07 sent with parity bit 0 → `rx_error` pulse, no `rx_done`. Sent with parity bit 1 → `rx_out`=0x07.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive path: FSM state codes and
// default frame geometry.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    // Codes are visible on the rstate debug port, so they are fixed.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_START     = 4'd1,
        ST_DATA      = 4'd2,
        ST_PARITY    = 4'd3,
        ST_STOP      = 4'd4,
        ST_WAIT_HIGH = 4'd5
    } rx_state_e;

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: divides clka by BAUD_DIV and emits a
// one-cycle tick. restart realigns the divider to the start edge.
module uart_baud_tick #(
    parameter int BAUD_DIV = 1
) (
    input  logic clka,
    input  logic reset,
    input  logic restart,
    output logic tick
);

    localparam int            CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(BAUD_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    // Next divider count: restart wins, otherwise count up and wrap at LAST.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart || (cnt_q == LAST)) cnt_d = '0;
    end

    // Divider register.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_deser.sv
// UART receive deserializer: 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined), start/stop validation, held-until-accepted byte handshake,
// sticky overrun and one-cycle error pulse.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE,
    parameter int BAUD_DIV   = 1
) (
    input  logic                 clka,
    input  logic                 reset,
    input  logic                 rxd,
    input  logic                 rx_rdy,
    output logic [DATA_BITS-1:0] rx_out,
    output logic                 rx_done,
    output logic                 rx_busy,
    output logic                 rx_idle,
    output logic                 rx_error,
    output logic                 rx_overrun,
    output logic [3:0]           rstate,
    output logic [3:0]           rcount
);

    localparam int            SW       = $clog2(OVERSAMPLE);
    // The start-edge cycle already counts as the first tick of the start
    // bit, so the midpoint is reached HALF-1 further ticks after entry.
    localparam logic [SW-1:0] S_HALF   = SW'(OVERSAMPLE / 2 - 2);
    localparam logic [SW-1:0] S_FULL   = SW'(OVERSAMPLE - 1);
    localparam logic [3:0]    LAST_BIT = 4'(DATA_BITS - 1);

    logic                 meta_q, sync_q;
    rx_state_e            state_q, state_d;
    logic [SW-1:0]        samp_q, samp_d;
    logic [3:0]           rcount_q, rcount_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] out_q, out_d;
    logic                 perr_q, perr_d;
    logic                 done_q, done_d;
    logic                 ovr_q, ovr_d;
    logic                 err_q, err_d;
    logic                 busy_q, idle_q;
    logic                 tick, start_edge, bit_end, accept, good_byte;

    // Two-flop synchronizer; idles high so reset never looks like a start.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= rxd;
            sync_q <= meta_q;
        end
    end

    // IDLE is only ever entered with the line sampled high, so a low
    // synchronized level seen in IDLE is a falling edge.
    assign start_edge = (state_q == ST_IDLE) && !sync_q;
    assign bit_end    = tick && (samp_q == S_FULL);
    assign accept     = done_q && rx_rdy;

    uart_baud_tick #(.BAUD_DIV(BAUD_DIV)) u_tick (
        .clka    (clka),
        .reset   (reset),
        .restart (start_edge),
        .tick    (tick)
    );

    // Frame FSM, shift register and delivery handshake next-state.
    always_comb begin
        state_d   = state_q;
        samp_d    = samp_q;
        rcount_d  = rcount_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        out_d     = out_q;
        done_d    = done_q;
        ovr_d     = ovr_q;
        err_d     = 1'b0;
        good_byte = 1'b0;
        if (tick) samp_d = samp_q + 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start_edge) begin
                    state_d  = ST_START;
                    samp_d   = '0;
                    rcount_d = '0;
                    perr_d   = 1'b0;
                end
            end
            ST_START: begin
                if (tick && (samp_q == S_HALF)) begin
                    samp_d  = '0;
                    state_d = sync_q ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    samp_d   = '0;
                    shift_d  = {sync_q, shift_q[DATA_BITS-1:1]};
                    rcount_d = rcount_q + 1'b1;
                    if (rcount_q == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (bit_end) begin
                    samp_d  = '0;
                    // Even parity: data ones plus parity bit must be even.
                    perr_d  = sync_q ^ (^shift_q);
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (bit_end) begin
                    samp_d = '0;
                    if (!sync_q) begin
                        err_d   = 1'b1;
                        state_d = ST_WAIT_HIGH;
                    end else if (perr_q) begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        good_byte = 1'b1;
                        state_d   = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (sync_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            done_d = 1'b0;
            ovr_d  = 1'b0;
        end
        // A byte accepted on this edge frees the slot for the new one.
        if (good_byte) begin
            if (!done_q || accept) begin
                out_d  = shift_q;
                done_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    // State and output registers; busy/idle follow the next state.
    always_ff @(posedge clka or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            samp_q   <= '0;
            rcount_q <= '0;
            shift_q  <= '0;
            perr_q   <= 1'b0;
            out_q    <= '0;
            done_q   <= 1'b0;
            ovr_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            idle_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            samp_q   <= samp_d;
            rcount_q <= rcount_d;
            shift_q  <= shift_d;
            perr_q   <= perr_d;
            out_q    <= out_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            err_q    <= err_d;
            busy_q   <= (state_d != ST_IDLE);
            idle_q   <= (state_d == ST_IDLE);
        end
    end

    assign rx_out     = out_q;
    assign rx_done    = done_q;
    assign rx_busy    = busy_q;
    assign rx_idle    = idle_q;
    assign rx_error   = err_q;
    assign rx_overrun = ovr_q;
    assign rstate     = state_q;
    assign rcount     = rcount_q;

endmodule

// File: tb/tb_uart_rx_deser.sv
// Bench for uart_rx_deser: directed cases plus random frames, checked by a
// scoreboard of expected byte/error events drained by a monitor.
module tb_uart_rx_deser;

    localparam int DB  = 8;
    localparam int OS  = 16;
    localparam int BIT = OS;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    // rxd fall to rx_done rise, in clka cycles.
    localparam int LAT = 2 + (OS / 2 - 1) + (DB + 1 + PAR) * BIT + 1;

    logic          clka = 1'b0;
    logic          reset = 1'b1;
    logic          rxd = 1'b1;
    logic          rx_rdy = 1'b1;
    logic [DB-1:0] rx_out;
    logic          rx_done, rx_busy, rx_idle, rx_error, rx_overrun;
    logic [3:0]    rstate, rcount;

    uart_rx_deser #(.DATA_BITS(DB), .OVERSAMPLE(OS), .BAUD_DIV(1)) dut (
        .clka       (clka),
        .reset      (reset),
        .rxd        (rxd),
        .rx_rdy     (rx_rdy),
        .rx_out     (rx_out),
        .rx_done    (rx_done),
        .rx_busy    (rx_busy),
        .rx_idle    (rx_idle),
        .rx_error   (rx_error),
        .rx_overrun (rx_overrun),
        .rstate     (rstate),
        .rcount     (rcount)
    );

    always #5 clka = ~clka;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   done_cyc = 0;
    int   done_hi_cnt = 0;
    int   rcount_max = 0;
    bit   saw_start = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clka);
        #1;
    endtask

    // Drives one frame bit by bit; cut>0 abandons it after that many cycles.
    // A frame with stop=0 leaves the line low on return.
    task automatic send_frame(input logic [7:0] d, input bit stop, input bit par_good,
                              input int cut, output int t0);
        logic [11:0] fr;
        int          nb;
        int          el;
        nb = 10 + PAR;
        fr = '1;
        fr[0] = 1'b0;
        for (int i = 0; i < 8; i++) fr[1+i] = d[i];
`ifdef UART_RX_PARITY_EN
        fr[9] = par_good ? (^d) : ~(^d);
`endif
        fr[nb-1] = stop;
        t0 = cyc;
        el = 0;
        for (int b = 0; b < nb; b++) begin
            rxd = fr[b];
            for (int c = 0; c < BIT; c++) begin
                tick1();
                el++;
                if (cut > 0 && el >= cut) begin
                    rxd = 1'b1;
                    return;
                end
            end
        end
        if (stop) rxd = 1'b1;
    endtask

    initial forever begin
        @(posedge clka);
        cyc++;
    end

    // Monitor: every newly presented byte or error pulse must match the
    // head of the scoreboard.
    initial begin
        bit   prev_done, prev_acc, prev_err;
        exp_t e;
        prev_done = 0;
        prev_acc  = 0;
        prev_err  = 0;
        forever begin
            @(negedge clka);
            if (reset) begin
                prev_done = 0;
                prev_acc  = 0;
                prev_err  = 0;
            end else begin
                if (rx_done) done_hi_cnt++;
                if (int'(rcount) > rcount_max) rcount_max = int'(rcount);
                if (rstate == 4'd1) saw_start = 1;
                if (rx_done && (!prev_done || prev_acc)) begin
                    done_cyc = cyc;
                    vectors++;
                    if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_byte: got byte %0h, expected no event", rx_out);
                    end else begin
                        e = sb.pop_front();
                        if (e.is_err || rx_out !== e.data) begin
                            miscompares++;
                            $display("FAIL sb_byte: got byte %0h, expected %s %0h",
                                     rx_out, e.is_err ? "error" : "byte", e.data);
                        end
                    end
                end
                if (rx_error) begin
                    vectors++;
                    if (prev_err) begin
                        miscompares++;
                        $display("FAIL err_width: got error pulse > 1 cycle, expected 1 cycle");
                    end else if (sb.size() == 0) begin
                        miscompares++;
                        $display("FAIL sb_err: got error, expected no event");
                    end else begin
                        e = sb.pop_front();
                        if (!e.is_err) begin
                            miscompares++;
                            $display("FAIL sb_err: got error, expected byte %0h", e.data);
                        end
                    end
                end
                prev_done = rx_done;
                prev_acc  = rx_done && rx_rdy;
                prev_err  = rx_error;
            end
        end
    end

    initial begin
        repeat (60000) @(posedge clka);
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_out"},   32'(rx_out), 0);
        chk({tag, "_done"},  32'(rx_done), 0);
        chk({tag, "_busy"},  32'(rx_busy), 0);
        chk({tag, "_idle"},  32'(rx_idle), 1);
        chk({tag, "_err"},   32'(rx_error), 0);
        chk({tag, "_ovr"},   32'(rx_overrun), 0);
        chk({tag, "_state"}, 32'(rstate), 0);
        chk({tag, "_cnt"},   32'(rcount), 0);
    endtask

    initial begin
        int         t0;
        int         kind;
        logic [7:0] d;

        repeat (3) tick1();
        chk_reset_vals("rst");
        reset = 1'b0;
        repeat (5) tick1();

        // Clean byte with rx_rdy held high.
        rcount_max  = 0;
        done_hi_cnt = 0;
        sb.push_back('{1'b0, 8'hE8});
        send_frame(8'hE8, 1'b1, 1'b1, 0, t0);
        repeat (4) tick1();
        chk("clean_latency", 32'(done_cyc - t0), 32'(LAT));
        chk("clean_out", 32'(rx_out), 32'hE8);
        chk("clean_done_width", 32'(done_hi_cnt), 1);
        chk("clean_rcount", 32'(rcount_max), 32'(DB));
        chk("clean_busy", 32'(rx_busy), 0);

        // Hold and overrun.
        rx_rdy = 1'b0;
        sb.push_back('{1'b0, 8'h55});
        send_frame(8'h55, 1'b1, 1'b1, 0, t0);
        send_frame(8'hAA, 1'b1, 1'b1, 0, t0);
        repeat (10) tick1();
        chk("ovr_done", 32'(rx_done), 1);
        chk("ovr_out", 32'(rx_out), 32'h55);
        chk("ovr_flag", 32'(rx_overrun), 1);
        rx_rdy = 1'b1;
        tick1();
        rx_rdy = 1'b0;
        chk("ovr_clr_done", 32'(rx_done), 0);
        chk("ovr_clr_flag", 32'(rx_overrun), 0);

        // Delivery and acceptance on the same edge.
        sb.push_back('{1'b0, 8'h12});
        send_frame(8'h12, 1'b1, 1'b1, 0, t0);
        sb.push_back('{1'b0, 8'h34});
        fork
            send_frame(8'h34, 1'b1, 1'b1, 0, t0);
            begin
                repeat (LAT - 1) tick1();
                rx_rdy = 1'b1;
                tick1();
                rx_rdy = 1'b0;
            end
        join
        chk("same_edge_out", 32'(rx_out), 32'h34);
        chk("same_edge_done", 32'(rx_done), 1);
        chk("same_edge_ovr", 32'(rx_overrun), 0);
        rx_rdy = 1'b1;
        repeat (3) tick1();

        // Glitch: short low pulse is a false start.
        saw_start = 0;
        rxd = 1'b0;
        repeat (4) tick1();
        rxd = 1'b1;
        repeat (30) tick1();
        chk("glitch_start_seen", 32'(saw_start), 1);
        chk("glitch_state", 32'(rstate), 0);

        // Framing error followed by a break.
        sb.push_back('{1'b1, 8'h00});
        send_frame(8'h3C, 1'b0, 1'b1, 0, t0);
        repeat (100 - BIT) tick1();
        chk("break_state", 32'(rstate), 5);
        chk("break_done", 32'(rx_done), 0);
        rxd = 1'b1;
        repeat (5) tick1();
        chk("break_exit", 32'(rstate), 0);

        // Reset in the middle of a frame, then a clean frame.
        send_frame(8'h99, 1'b1, 1'b1, 60, t0);
        reset = 1'b1;
        tick1();
        chk_reset_vals("midrst");
        reset = 1'b0;
        repeat (5) tick1();
        sb.push_back('{1'b0, 8'h81});
        send_frame(8'h81, 1'b1, 1'b1, 0, t0);
        repeat (4) tick1();
        chk("after_rst_out", 32'(rx_out), 32'h81);

`ifdef UART_RX_PARITY_EN
        sb.push_back('{1'b1, 8'h00});
        send_frame(8'h07, 1'b1, 1'b0, 0, t0);
        repeat (10) tick1();
        sb.push_back('{1'b0, 8'h07});
        send_frame(8'h07, 1'b1, 1'b1, 0, t0);
        repeat (4) tick1();
        chk("parity_out", 32'(rx_out), 32'h07);
`endif

        // Random traffic.
        for (int i = 0; i < 24; i++) begin
            d    = 8'($urandom);
            kind = int'($urandom_range(0, 9));
            if (kind == 7) begin
                sb.push_back('{1'b1, 8'h00});
                send_frame(d, 1'b0, 1'b1, 0, t0);
                repeat ($urandom_range(5, 40)) tick1();
                rxd = 1'b1;
                repeat (8) tick1();
            end else if (kind == 8) begin
                rxd = 1'b0;
                repeat ($urandom_range(1, 5)) tick1();
                rxd = 1'b1;
                repeat (25) tick1();
            end else if (kind == 9 && PAR == 1) begin
                sb.push_back('{1'b1, 8'h00});
                send_frame(d, 1'b1, 1'b0, 0, t0);
            end else begin
                sb.push_back('{1'b0, d});
                send_frame(d, 1'b1, 1'b1, 0, t0);
            end
            repeat ($urandom_range(0, 12)) tick1();
        end

        repeat (40) tick1();
        chk("sb_drained", 32'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
